lenet_layer_sequencer: RTL and testbench

- Top-level scheduler for the LeNet-5 inference chain: conv_1 → pool_1 → conv_2 → pool_2 → fc.
- Enables exactly one layer at a time and waits for its finish flag before moving on.
- Arbitrates the two shared single-port BRAMs (bias/weights ROM, result RAM) so that only the active layer drives them.
- BRAM read data (douta) is broadcast to all layers outside this block; only the request side is muxed here.

---
 rtl/lenet_pkg.sv | 28 ++
 rtl/lenet_bram_port_mux.sv | 55 +++++
 rtl/lenet_layer_sequencer.sv | 172 +++++++++++++++++
 tb/tb_lenet_layer_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Purpose: shared constants, layer indices and sequencer state encodings for the LeNet-5 chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lenet_pkg;

  // Layer order in the inference chain; index 0 runs first.
  localparam int L_CONV1 = 0;
  localparam int L_POOL1 = 1;
  localparam int L_CONV2 = 2;
  localparam int L_POOL2 = 3;
  localparam int L_FC    = 4;

  localparam int BW_ADDR_W   = 16;
  localparam int RES_ADDR_W  = 13;
  localparam int DATA_SIZE   = 16;
  localparam int CUR_LAYER_W = 3;

  // One-hot sequencer states.
  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_CLEAR = 6'b000010,
    S_RUN   = 6'b000100,
    S_GAP   = 6'b001000,
    S_DONE  = 6'b010000,
    S_ERROR = 6'b100000
  } seq_state_e;

endpackage

// File: rtl/lenet_bram_port_mux.sv
// Purpose: N-way request mux for the bias/weights ROM and the result RAM, selected by the active layer.
// Latency: 0 cycles, purely combinational so layer read-wait timing is untouched.
// Backpressure: none; enables are forced low when sel_vld is low, other requesters are dropped.
//
// Ports:
//   sel, sel_vld                  active layer index and gate (enables pass only when sel_vld=1)
//   *_req                         packed per-layer requests, layer i at slice [i*W +: W]
//   bw_ena, bw_addra              bias/weights BRAM port
//   res_ena, res_wea, res_addra, res_dina   result BRAM port
module lenet_bram_port_mux #(
  parameter int NL    = 5,
  parameter int BW_W  = 16,
  parameter int RES_W = 13,
  parameter int DW    = 16,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_vld,
  input  logic [NL-1:0]       bw_ena_req,
  input  logic [NL*BW_W-1:0]  bw_addra_req,
  input  logic [NL-1:0]       res_ena_req,
  input  logic [NL-1:0]       res_wea_req,
  input  logic [NL*RES_W-1:0] res_addra_req,
  input  logic [NL*DW-1:0]    res_dina_req,
  output logic                bw_ena,
  output logic [BW_W-1:0]     bw_addra,
  output logic                res_ena,
  output logic                res_wea,
  output logic [RES_W-1:0]    res_addra,
  output logic [DW-1:0]       res_dina
);
  import lenet_pkg::*;

  // Address/data follow sel unconditionally (don't-care when gated off);
  // only the strobes are qualified so an idle phase can never write.
  always_comb begin
    bw_ena    = 1'b0;
    bw_addra  = '0;
    res_ena   = 1'b0;
    res_wea   = 1'b0;
    res_addra = '0;
    res_dina  = '0;
    for (int i = 0; i < NL; i++) begin
      if (sel == SEL_W'(i)) begin
        bw_ena    = sel_vld & bw_ena_req[i];
        bw_addra  = bw_addra_req[i*BW_W +: BW_W];
        res_ena   = sel_vld & res_ena_req[i];
        res_wea   = sel_vld & res_wea_req[i];
        res_addra = res_addra_req[i*RES_W +: RES_W];
        res_dina  = res_dina_req[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Purpose: runs conv_1 -> pool_1 -> conv_2 -> pool_2 -> fc one layer at a time and owns the shared BRAM ports.
// Latency: start -> layer_rst 1 cycle, -> first layer_en 2 cycles; finish -> next layer_en 2 cycles (1-cycle gap).
// Backpressure: start is ignored while busy; a layer that never finishes is cut off by the watchdog.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start                         request one inference (accepted in S_IDLE / S_ERROR)
//   layer_rst, layer_en           one-cycle layer reset pulse, registered one-hot layer enable
//   layer_finish                  per-layer finish flags
//   bw_*_req, res_*_req           per-layer BRAM requests
//   bias_weights_bram_*, result_bram_*   arbitrated BRAM ports
//   cur_layer, busy, done, error  status: active index, not idle, end-of-chain pulse, sticky watchdog flag
module lenet_layer_sequencer #(
  parameter int N_LAYERS       = 5,
  parameter int BW_ADDR_W      = lenet_pkg::BW_ADDR_W,
  parameter int RES_ADDR_W     = lenet_pkg::RES_ADDR_W,
  parameter int DATA_SIZE      = lenet_pkg::DATA_SIZE,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           layer_rst,
  output logic [N_LAYERS-1:0]            layer_en,
  input  logic [N_LAYERS-1:0]            layer_finish,
  input  logic [N_LAYERS-1:0]            bw_ena_req,
  input  logic [N_LAYERS*BW_ADDR_W-1:0]  bw_addra_req,
  input  logic [N_LAYERS-1:0]            res_ena_req,
  input  logic [N_LAYERS-1:0]            res_wea_req,
  input  logic [N_LAYERS*RES_ADDR_W-1:0] res_addra_req,
  input  logic [N_LAYERS*DATA_SIZE-1:0]  res_dina_req,
  output logic                           bias_weights_bram_ena,
  output logic [BW_ADDR_W-1:0]           bias_weights_bram_addra,
  output logic                           result_bram_ena,
  output logic                           result_bram_wea,
  output logic [RES_ADDR_W-1:0]          result_bram_addra,
  output logic [DATA_SIZE-1:0]           result_bram_dina,
  output logic [2:0]                     cur_layer,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);
  import lenet_pkg::*;

  localparam int              WD_W       = 32;
  localparam logic [WD_W-1:0] WD_LAST    = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [2:0]      LAST_LAYER = 3'(N_LAYERS - 1);

  seq_state_e          state_q, state_d;
  logic [2:0]          cur_layer_q, cur_layer_d;
  logic [N_LAYERS-1:0] layer_en_q, layer_en_d;
  logic                error_q, error_d;
  logic                armed_q, armed_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                fin_cur;
  logic                wd_expire;

  // Finish flag of the active layer only; all others are ignored.
  always_comb begin
    fin_cur = 1'b0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (cur_layer_q == 3'(i)) fin_cur = layer_finish[i];
    end
  end

  // wd_cnt_q counts completed S_RUN cycles, so it equals TIMEOUT-1 in the TIMEOUT-th cycle.
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    cur_layer_d = cur_layer_q;
    error_d     = error_q;
    armed_d     = 1'b0;
    wd_cnt_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d     = 1'b0;
          cur_layer_d = '0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // A finish is only trusted once the layer has been seen with its flag low,
        // which rejects a flag left over from a previous run.
        armed_d  = armed_q | ~fin_cur;
        if (armed_q && fin_cur) begin
          state_d = S_GAP;
        end else if (wd_expire) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_GAP: begin
        if (cur_layer_q == LAST_LAYER) begin
          state_d = S_DONE;
        end else begin
          cur_layer_d = cur_layer_q + 1'b1;
          state_d     = S_RUN;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERROR: begin
        if (start) begin
          error_d     = 1'b0;
          cur_layer_d = '0;
          state_d     = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Enable is registered from the next state so it is high exactly during S_RUN.
  always_comb begin
    layer_en_d = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      layer_en_d[i] = (state_d == S_RUN) && (cur_layer_d == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_layer_q <= '0;
      layer_en_q  <= '0;
      error_q     <= 1'b0;
      armed_q     <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_layer_q <= cur_layer_d;
      layer_en_q  <= layer_en_d;
      error_q     <= error_d;
      armed_q     <= armed_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign layer_rst = (state_q == S_CLEAR);
  assign layer_en  = layer_en_q;
  assign cur_layer = cur_layer_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;

  lenet_bram_port_mux #(
    .NL    (N_LAYERS),
    .BW_W  (BW_ADDR_W),
    .RES_W (RES_ADDR_W),
    .DW    (DATA_SIZE),
    .SEL_W (3)
  ) u_port_mux (
    .sel           (cur_layer_q),
    .sel_vld       (state_q == S_RUN),
    .bw_ena_req    (bw_ena_req),
    .bw_addra_req  (bw_addra_req),
    .res_ena_req   (res_ena_req),
    .res_wea_req   (res_wea_req),
    .res_addra_req (res_addra_req),
    .res_dina_req  (res_dina_req),
    .bw_ena        (bias_weights_bram_ena),
    .bw_addra      (bias_weights_bram_addra),
    .res_ena       (result_bram_ena),
    .res_wea       (result_bram_wea),
    .res_addra     (result_bram_addra),
    .res_dina      (result_bram_dina)
  );

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Purpose: self-checking bench for lenet_layer_sequencer with behavioural layer models.
// Latency: n/a.
// Backpressure: n/a.
module tb_lenet_layer_sequencer;

  localparam int NL = 5;

  typedef struct packed {
    logic [4:0]  en;
    logic [15:0] len;
    logic [2:0]  cur;
    logic        bw_ena;
    logic [15:0] bw_addr;
    logic        res_ena;
    logic        res_wea;
    logic [12:0] res_addr;
    logic [15:0] dina;
    logic        off_ena;
    logic        off_err;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        layer_rst;
  logic [4:0]  layer_en;
  logic [4:0]  layer_finish;
  logic [4:0]  bw_ena_req;
  logic [79:0] bw_addra_req;
  logic [4:0]  res_ena_req;
  logic [4:0]  res_wea_req;
  logic [64:0] res_addra_req;
  logic [79:0] res_dina_req;
  logic        bias_weights_bram_ena;
  logic [15:0] bias_weights_bram_addra;
  logic        result_bram_ena;
  logic        result_bram_wea;
  logic [12:0] result_bram_addra;
  logic [15:0] result_bram_dina;
  logic [2:0]  cur_layer;
  logic        busy;
  logic        done;
  logic        error;

  logic        noise = 1'b0;
  logic [4:0]  stale_m = '0;
  int          delay_m [5] = '{50, 50, 50, 50, 50};
  logic [4:0]  fin_m;
  int          cnt_m [5];

  int   n_checks = 0;
  int   n_pass = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  int   obs_rd = 0;

  logic [59:0] all_out;
  assign all_out = {layer_en, layer_rst, cur_layer, busy, done, error,
                    bias_weights_bram_ena, bias_weights_bram_addra,
                    result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina};

  always #5 clk = ~clk;

  lenet_layer_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_rst(layer_rst), .layer_en(layer_en),
    .layer_finish(layer_finish), .bw_ena_req(bw_ena_req), .bw_addra_req(bw_addra_req),
    .res_ena_req(res_ena_req), .res_wea_req(res_wea_req), .res_addra_req(res_addra_req),
    .res_dina_req(res_dina_req), .bias_weights_bram_ena(bias_weights_bram_ena),
    .bias_weights_bram_addra(bias_weights_bram_addra), .result_bram_ena(result_bram_ena),
    .result_bram_wea(result_bram_wea), .result_bram_addra(result_bram_addra),
    .result_bram_dina(result_bram_dina), .cur_layer(cur_layer), .busy(busy), .done(done),
    .error(error)
  );

  function automatic logic [15:0] bw_pat(input int i);
    return 16'(16'h0100 + i * 16'h1100);
  endfunction

  function automatic logic [12:0] res_pat(input int i);
    return (i == 2) ? 13'd5880 : 13'(i * 1000);
  endfunction

  function automatic logic [15:0] dina_pat(input int i);
    return 16'(16'hA5A0 + i * 3);
  endfunction

  // Layer models: every layer (or all of them, with noise) drives its own request pattern.
  for (genvar g = 0; g < NL; g++) begin : g_req
    assign bw_ena_req[g]             = layer_en[g] | noise;
    assign res_ena_req[g]            = layer_en[g] | noise;
    assign res_wea_req[g]            = layer_en[g] | noise;
    assign bw_addra_req[g*16 +: 16]  = (layer_en[g] | noise) ? bw_pat(g) : 16'h0;
    assign res_addra_req[g*13 +: 13] = (layer_en[g] | noise) ? res_pat(g) : 13'h0;
    assign res_dina_req[g*16 +: 16]  = (layer_en[g] | noise) ? dina_pat(g) : 16'h0;
  end

  // Finish flag clears on the first enabled cycle and rises after delay_m enabled cycles.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (rst) begin
        fin_m[i] <= 1'b0;
        cnt_m[i] <= 0;
      end else if (layer_rst) begin
        fin_m[i] <= stale_m[i];
        cnt_m[i] <= 0;
      end else if (layer_en[i]) begin
        if (cnt_m[i] == 0) fin_m[i] <= 1'b0;
        if (delay_m[i] != 0 && cnt_m[i] + 1 == delay_m[i]) fin_m[i] <= 1'b1;
        cnt_m[i] <= cnt_m[i] + 1;
      end
    end
  end
  assign layer_finish = fin_m;

  // Records one entry per enable window: first-cycle BRAM port, length, and the cycle after.
  rec_t       mon_r;
  logic [4:0] mon_prev = '0;
  always @(negedge clk) begin
    if (layer_en != '0) begin
      if (mon_prev == '0) begin
        mon_r          = '0;
        mon_r.en       = layer_en;
        mon_r.cur      = cur_layer;
        mon_r.bw_ena   = bias_weights_bram_ena;
        mon_r.bw_addr  = bias_weights_bram_addra;
        mon_r.res_ena  = result_bram_ena;
        mon_r.res_wea  = result_bram_wea;
        mon_r.res_addr = result_bram_addra;
        mon_r.dina     = result_bram_dina;
      end
      mon_r.len = mon_r.len + 16'd1;
    end else if (mon_prev != '0) begin
      mon_r.off_ena = bias_weights_bram_ena | result_bram_ena | result_bram_wea;
      mon_r.off_err = error;
      obs_q.push_back(mon_r);
    end
    mon_prev = layer_en;
  end

  function automatic rec_t mk(input int i, input int len, input logic err);
    rec_t r;
    r          = '0;
    r.en       = 5'(1 << i);
    r.len      = 16'(len);
    r.cur      = 3'(i);
    r.bw_ena   = 1'b1;
    r.bw_addr  = bw_pat(i);
    r.res_ena  = 1'b1;
    r.res_wea  = 1'b1;
    r.res_addr = res_pat(i);
    r.dina     = dina_pat(i);
    r.off_ena  = 1'b0;
    r.off_err  = err;
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_collect(input int budget, input logic hold, output int done_n,
                             output int lrst_n, output logic busy_after, output logic finished);
    logic prev_done;
    prev_done  = 1'b0;
    done_n     = 0;
    lrst_n     = 0;
    busy_after = 1'b1;
    finished   = 1'b0;
    for (int c = 0; c < budget && !finished; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (prev_done) busy_after = busy;
      prev_done = done;
      if (done) done_n++;
      if (layer_rst) lrst_n++;
      if (!busy) finished = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; noise = 1'b0;
    cyc(3);
    n_checks++;
    if (all_out !== 60'h0) $display("FAIL reset_outputs: got %h want 0", all_out);
    else n_pass++;
    rst = 1'b0;
    cyc(5);
    n_checks++;
    if ({busy, layer_en, layer_rst, done} !== 8'h0) $display("FAIL idle_hold: got %b want 0", {busy, layer_en, layer_rst, done});
    else n_pass++;
  endtask

  task automatic test_sequence();
    int dn, ln; logic ba, fin; rec_t e, o;
    noise = 1'b1;
    for (int i = 0; i < NL; i++) exp_q.push_back(mk(i, 51, 1'b0));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    n_checks++;
    if ({layer_rst, busy, layer_en} !== 7'b1100000) $display("FAIL clear_cycle: got %b want 1100000", {layer_rst, busy, layer_en});
    else n_pass++;
    cyc(1);
    n_checks++;
    if ({layer_rst, layer_en, cur_layer} !== 9'b0_00001_000) $display("FAIL first_run: got %b want 000001000", {layer_rst, layer_en, cur_layer});
    else n_pass++;
    run_collect(600, 1'b0, dn, ln, ba, fin);
    n_checks++;
    if ({fin, dn == 1, ba} !== 3'b110) $display("FAIL seq_done: got fin=%b done_n=%0d busy_after=%b want 1/1/0", fin, dn, ba);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL seq_record: got none want %h", e);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL seq_record: got %h want %h", o, e); else n_pass++;
      end
    end
    noise = 1'b0;
  endtask

  task automatic test_stale_finish();
    int dn, ln; logic ba, fin; rec_t e, o;
    stale_m[2] = 1'b1;
    delay_m[2] = 30;
    for (int i = 0; i < NL; i++) exp_q.push_back(mk(i, (i == 2) ? 31 : 51, 1'b0));
    start = 1'b1;
    run_collect(600, 1'b0, dn, ln, ba, fin);
    n_checks++;
    if ({fin, dn == 1, ln == 1} !== 3'b111) $display("FAIL stale_run: got fin=%b done_n=%0d lrst_n=%0d want 1/1/1", fin, dn, ln);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL stale_record: got none want %h", e);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL stale_record: got %h want %h", o, e); else n_pass++;
      end
    end
    stale_m[2] = 1'b0;
    delay_m[2] = 50;
  endtask

  task automatic test_busy_events();
    int dn, ln; logic ba, fin; rec_t e, o;
    // Layer 3 finishes in the very cycle its watchdog expires; start stays high throughout.
    delay_m[3] = 99;
    for (int i = 0; i < NL; i++) exp_q.push_back(mk(i, (i == 3) ? 100 : 51, 1'b0));
    start = 1'b1;
    run_collect(700, 1'b1, dn, ln, ba, fin);
    start = 1'b0;
    n_checks++;
    if ({fin, dn == 1, ln == 1, error} !== 4'b1110) $display("FAIL busy_run: got fin=%b done_n=%0d lrst_n=%0d err=%b want 1/1/1/0", fin, dn, ln, error);
    else n_pass++;
    cyc(2);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL no_restart: got busy=%b want 0", busy);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL busy_record: got none want %h", e);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL busy_record: got %h want %h", o, e); else n_pass++;
      end
    end
    delay_m[3] = 50;
  endtask

  task automatic test_watchdog();
    int dn, ln, c; logic ba, fin; rec_t e, o;
    noise = 1'b1;
    delay_m[1] = 0;
    exp_q.push_back(mk(0, 51, 1'b0));
    exp_q.push_back(mk(1, 100, 1'b1));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    c = 0;
    while (error !== 1'b1 && c < 400) begin
      cyc(1);
      c++;
    end
    n_checks++;
    if (error !== 1'b1) $display("FAIL wd_error_set: got %b want 1", error);
    else n_pass++;
    n_checks++;
    if ({busy, layer_en, bias_weights_bram_ena, result_bram_ena, result_bram_wea} !== 9'b1_00000_000)
      $display("FAIL wd_error_outputs: got %b want 100000000", {busy, layer_en, bias_weights_bram_ena, result_bram_ena, result_bram_wea});
    else n_pass++;
    cyc(5);
    n_checks++;
    if ({error, busy, layer_en} !== 7'b1100000) $display("FAIL wd_sticky: got %b want 1100000", {error, busy, layer_en});
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL wd_record: got none want %h", e);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL wd_record: got %h want %h", o, e); else n_pass++;
      end
    end
    delay_m[1] = 50;
    for (int i = 0; i < NL; i++) exp_q.push_back(mk(i, 51, 1'b0));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    n_checks++;
    if ({error, layer_rst, cur_layer} !== 5'b01000) $display("FAIL wd_restart: got %b want 01000", {error, layer_rst, cur_layer});
    else n_pass++;
    run_collect(600, 1'b0, dn, ln, ba, fin);
    n_checks++;
    if ({fin, dn == 1, ba, error} !== 4'b1100) $display("FAIL wd_rerun: got fin=%b done_n=%0d busy_after=%b err=%b want 1/1/0/0", fin, dn, ba, error);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL wd_rerun_record: got none want %h", e);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL wd_rerun_record: got %h want %h", o, e); else n_pass++;
      end
    end
    noise = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    int dn, ln, c; logic ba, fin; rec_t e, o;
    noise = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    c = 0;
    while (layer_en !== 5'b00100 && c < 300) begin
      cyc(1);
      c++;
    end
    n_checks++;
    if (layer_en !== 5'b00100) $display("FAIL reach_conv2: got %b want 00100", layer_en);
    else n_pass++;
    cyc(10);
    rst = 1'b1;
    cyc(1);
    n_checks++;
    if (all_out !== 60'h0) $display("FAIL rst_mid_outputs: got %h want 0", all_out);
    else n_pass++;
    rst = 1'b0;
    cyc(2);
    obs_rd = obs_q.size();
    for (int i = 0; i < NL; i++) exp_q.push_back(mk(i, 51, 1'b0));
    start = 1'b1;
    run_collect(600, 1'b0, dn, ln, ba, fin);
    n_checks++;
    if ({fin, dn == 1, ln == 1, ba} !== 4'b1110) $display("FAIL rst_rerun: got fin=%b done_n=%0d lrst_n=%0d busy_after=%b want 1/1/1/0", fin, dn, ln, ba);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd >= obs_q.size()) $display("FAIL rst_record: got none want %h", e);
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL rst_record: got %h want %h", o, e); else n_pass++;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_sequence();
    test_stale_finish();
    test_busy_events();
    test_watchdog();
    test_rst_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
